// File: rtl/if_prefetch_pkg.sv
// Shared constants for the instruction-fetch prefetch unit.
//   RESET_VECTOR : first fetch word address after reset
//   ISA_NOP      : bubble encoding loaded into IF/ID when no instruction is valid
//   ENABLE/DISABLE, RESET_ENABLE/RESET_EDGE : readable names for control levels
package if_prefetch_pkg;
  localparam logic [29:0] RESET_VECTOR = 30'h0;
  localparam logic [31:0] ISA_NOP      = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic        ENABLE       = 1'b1;
  localparam logic        DISABLE      = 1'b0;
  localparam logic        RESET_ENABLE = 1'b0;  // reset asserted when low
  localparam logic        RESET_EDGE   = 1'b0;  // reset acts on the falling edge
endpackage

// File: rtl/if_prefetch_if.sv
// Bus bundle for if_prefetch: instruction-memory request/response, pipeline
// control (stall/flush/branch) and the IF/ID register outputs.
//   master : the fetch unit side
//   slave  : the environment (memory + ID stage + hazard control)
interface if_prefetch_if #(
  parameter int PC_W   = 30,
  parameter int INSN_W = 32
) ();
  logic              fetch_req;
  logic [PC_W-1:0]   fetch_addr;
  logic              fetch_ack;
  logic              rsp_valid;
  logic [INSN_W-1:0] rsp_insn;
  logic              stall;
  logic              flush;
  logic [PC_W-1:0]   new_pc;
  logic              br_taken;
  logic [PC_W-1:0]   br_addr;
  logic [PC_W-1:0]   if_pc;
  logic [INSN_W-1:0] if_insn;
  logic              if_en;

  modport master (
    output fetch_req, fetch_addr, if_pc, if_insn, if_en,
    input  fetch_ack, rsp_valid, rsp_insn, stall, flush, new_pc, br_taken, br_addr
  );
  modport slave (
    input  fetch_req, fetch_addr, if_pc, if_insn, if_en,
    output fetch_ack, rsp_valid, rsp_insn, stall, flush, new_pc, br_taken, br_addr
  );
endinterface

// File: rtl/if_prefetch_fifo.sv
// if_fifo: DEPTH-entry synchronous FIFO holding {pc, insn} words.
//   push/din  : write one entry      pop/dout : head entry, advance on pop
//   clear     : drop all entries     full/empty/count : occupancy
// DEPTH must be a power of two so the pointers wrap on natural overflow.
module if_fifo #(
  parameter int W     = 62,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PTR_W'(1);
      if (pop)  rd_q <= rd_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end

  assign dout  = mem_q[rd_q];
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: fetch unit with a DEPTH-entry prefetch queue feeding IF/ID.
//   clk, reset (async, active low)
//   bus.master : fetch_req/fetch_addr/fetch_ack request side,
//                rsp_valid/rsp_insn in-order responses,
//                stall/flush/new_pc/br_taken/br_addr control,
//                if_pc/if_insn/if_en IF/ID register.
// Requests are credited so queued + in-flight never exceeds DEPTH; on a
// redirect the queue is cleared and every still-outstanding response is
// counted into drop_cnt and discarded on arrival.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int                PC_W         = 30,
  parameter int                INSN_W       = 32,
  parameter int                DEPTH        = 4,
  parameter logic [PC_W-1:0]   RESET_VECTOR = PC_W'(if_prefetch_pkg::RESET_VECTOR),
  parameter logic [INSN_W-1:0] NOP_INSN     = INSN_W'(ISA_NOP)
) (
  input  logic          clk,
  input  logic          reset,
  if_prefetch_if.master bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int W     = PC_W + INSN_W;

  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, if_pc_q, if_pc_d, target;
  logic [INSN_W-1:0] if_insn_q, if_insn_d;
  logic              if_en_q, if_en_d;
  logic [CNT_W-1:0]  outst_q, outst_d, drop_q, drop_d, count;
  logic [CNT_W:0]    credit_used;
  logic              redirect, accept, keep, pop, full, empty;
  logic [W-1:0]      head;

  assign redirect    = bus.flush | bus.br_taken;
  assign target      = bus.flush ? bus.new_pc : bus.br_addr;
  assign credit_used = {1'b0, count} + {1'b0, outst_q};

  // Gated by reset so no request is presented while the unit is held.
  assign bus.fetch_req  = reset & (credit_used < (CNT_W+1)'(DEPTH)) & ~redirect;
  assign bus.fetch_addr = fetch_pc_q;
  assign accept         = bus.fetch_req & bus.fetch_ack;
  // A response in a redirect cycle belongs to the old stream and is dropped.
  assign keep           = bus.rsp_valid & (drop_q == '0) & ~redirect;
  assign pop            = ~redirect & ~bus.stall & ~empty;

  if_fifo #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (keep),
    .pop   (pop),
    .clear (redirect),
    .din   ({rsp_pc_q, bus.rsp_insn}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    outst_d    = outst_q + CNT_W'(accept) - CNT_W'(bus.rsp_valid);
    drop_d     = drop_q;
    if_pc_d    = if_pc_q;
    if_insn_d  = if_insn_q;
    if_en_d    = if_en_q;

    if (accept)                           fetch_pc_d = fetch_pc_q + PC_W'(1);
    if (keep)                             rsp_pc_d   = rsp_pc_q + PC_W'(1);
    if (bus.rsp_valid && drop_q != '0)    drop_d     = drop_q - CNT_W'(1);

    if (!bus.stall) begin
      if (!empty) begin
        {if_pc_d, if_insn_d} = head;
        if_en_d              = ENABLE;
      end else begin
        if_insn_d = NOP_INSN;
        if_en_d   = DISABLE;
      end
    end

    // Redirect overrides everything, stalled or not.
    if (redirect) begin
      fetch_pc_d = target;
      rsp_pc_d   = target;
      drop_d     = outst_d;
      if_pc_d    = target;
      if_insn_d  = NOP_INSN;
      if_en_d    = DISABLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_VECTOR;
      rsp_pc_q   <= RESET_VECTOR;
      outst_q    <= '0;
      drop_q     <= '0;
      if_pc_q    <= RESET_VECTOR;
      if_insn_q  <= NOP_INSN;
      if_en_q    <= DISABLE;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      if_pc_q    <= if_pc_d;
      if_insn_q  <= if_insn_d;
      if_en_q    <= if_en_d;
    end
  end

  assign bus.if_pc   = if_pc_q;
  assign bus.if_insn = if_insn_q;
  assign bus.if_en   = if_en_q;

  a_keep_not_full: assert property (@(posedge clk) disable iff (!reset) !(keep && full));
endmodule
